hazard_ctl: RTL

- Pipeline hazard controller upstream of the ID/EX control pipeline register.
- Receives the decoded ID-stage control bundle and decides each cycle whether it is issued, replaced by a bubble, or held.
- Drives PC / IF-ID enables and flushes, and keeps shadow copies of the EX-stage rd, memRead and regWrite for load-use detection.
- Keeps saturating stall/flush performance counters.

---
 rtl/hazard_ctl_pkg.sv | 27 ++
 rtl/hazard_ctl_sat_counter.sv | 23 ++
 rtl/hazard_ctl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/hazard_ctl_pkg.sv
// Shared types for the hazard controller: cause encoding and the ID/EX control bundle.
package hazard_ctl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_FLUSH    = 2'd2,
    HZ_MEM_WAIT = 2'd3
  } hz_state_e;

  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CTRL_W = 5 + 3 * SEL_W;

  typedef struct packed {
    logic             memRead;
    logic             memWrite;
    logic             pcSel;
    logic             ALUOp;
    logic             regWrite;
    logic [SEL_W-1:0] ASel;
    logic [SEL_W-1:0] BSel;
    logic [SEL_W-1:0] writeBackSel;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_ctl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctl.sv
// Issue/bubble/hold decision for the ID stage, with load-use shadow of EX and perf counters.
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_memRead,
  input  logic              id_memWrite,
  input  logic              id_pcSel,
  input  logic              id_ALUOp,
  input  logic              id_regWrite,
  input  logic [1:0]        id_ASel,
  input  logic [1:0]        id_BSel,
  input  logic [1:0]        id_writeBackSel,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic              ifid_flush,
  output logic              pipe_en,
  output logic              memRead_o,
  output logic              memWrite_o,
  output logic              pcSel_o,
  output logic              ALUOp_o,
  output logic              regWrite_o,
  output logic [1:0]        ASel_o,
  output logic [1:0]        BSel_o,
  output logic [1:0]        writeBackSel_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [1:0]        hz_state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_t             id_ctrl;
  ctrl_t             ctrl_o;
  hz_state_e         cause_d, hz_state_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic              ex_memRead_q, ex_regWrite_q;
  logic              lu_hit;

  assign id_ctrl = '{memRead: id_memRead, memWrite: id_memWrite, pcSel: id_pcSel,
                     ALUOp: id_ALUOp, regWrite: id_regWrite, ASel: id_ASel,
                     BSel: id_BSel, writeBackSel: id_writeBackSel};

  assign lu_hit = id_valid && ex_memRead_q && (ex_rd_q != '0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd_q)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd_q)));

  always_comb begin
    cause_d = HZ_RUN;
    if (mem_req && !mem_ready)  cause_d = HZ_MEM_WAIT;
    else if (ex_branch_taken)   cause_d = HZ_FLUSH;
    else if (lu_hit)            cause_d = HZ_LU_STALL;
  end

  // Held in reset, the outputs present the RUN defaults with a bubble bundle.
  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    pipe_en       = 1'b1;
    ctrl_o        = CTRL_NOP;
    ex_rd_o       = '0;
    if (rst) begin
      unique case (cause_d)
        HZ_RUN: begin
          if (id_valid) begin
            ctrl_o  = id_ctrl;
            ex_rd_o = id_rd;
          end
        end
        HZ_LU_STALL: begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
        end
        HZ_FLUSH: begin
          ifid_flush = 1'b1;
        end
        HZ_MEM_WAIT: begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          pipe_en       = 1'b0;
          if (id_valid) begin
            ctrl_o  = id_ctrl;
            ex_rd_o = id_rd;
          end
        end
        default: ;
      endcase
    end
  end

  assign memRead_o      = ctrl_o.memRead;
  assign memWrite_o     = ctrl_o.memWrite;
  assign pcSel_o        = ctrl_o.pcSel;
  assign ALUOp_o        = ctrl_o.ALUOp;
  assign regWrite_o     = ctrl_o.regWrite;
  assign ASel_o         = ctrl_o.ASel;
  assign BSel_o         = ctrl_o.BSel;
  assign writeBackSel_o = ctrl_o.writeBackSel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_rd_q       <= '0;
      ex_memRead_q  <= 1'b0;
      ex_regWrite_q <= 1'b0;
      hz_state_q    <= HZ_RUN;
    end else begin
      hz_state_q <= cause_d;
      if (pipe_en) begin
        ex_rd_q       <= ex_rd_o;
        ex_memRead_q  <= memRead_o;
        ex_regWrite_q <= regWrite_o;
      end
    end
  end

  assign hz_state = hz_state_q;

  logic stall_inc, flush_inc, unused_regwrite;
  assign stall_inc       = (cause_d == HZ_LU_STALL) || (cause_d == HZ_MEM_WAIT);
  assign flush_inc       = (cause_d == HZ_FLUSH);
  assign unused_regwrite = ex_regWrite_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (stall_inc),
    .cnt_o  (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (flush_inc),
    .cnt_o  (flush_cnt)
  );

endmodule
